// File: rtl/sync_debounce_edge.sv
// sync_debounce_edge
//   Debounce and edge-detect stage that sits right after a 2-FF synchronizer.
//   Each bit of sync_in must present DB_CYCLES consecutive samples that differ
//   from the current debounced level before db_out follows it. Every accepted
//   change produces a single-cycle rise or fall pulse. A run that is abandoned
//   before completing (input returns to the debounced level) is a glitch, and
//   glitches are tallied in a saturating counter.
//
//   Build option: define GLITCH_CNT_EN to build the glitch counter and the
//   clr_cnt clear. Without it (the default build), glitch_cnt is tied to 0,
//   clr_cnt is ignored, and the debounce/edge behaviour does not change.
//
// Ports
//   clk         in   1      rising-edge clock for all state
//   rst_n       in   1      asynchronous active-low reset
//   sync_in     in   WIDTH  synchronized input bus
//   clr_cnt     in   1      synchronous clear of glitch_cnt (wins over glitches)
//   db_out      out  WIDTH  debounced level, registered
//   rise        out  WIDTH  one-cycle pulse on a debounced 0->1 change
//   fall        out  WIDTH  one-cycle pulse on a debounced 1->0 change
//   glitch_cnt  out  CNT_W  saturating count of aborted transitions

module sync_debounce_edge #(
    parameter int WIDTH     = 4,
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sync_in,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] db_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [CNT_W-1:0] glitch_cnt
);

    localparam int C_W   = $clog2(DB_CYCLES + 1);
    localparam int POP_W = $clog2(WIDTH + 1);
    localparam int SUM_W = CNT_W + POP_W;
    localparam logic [C_W-1:0] C_LAST = C_W'(DB_CYCLES - 1);

    // Per-bit run length of consecutive samples that differ from db_out.
    logic [C_W-1:0]   run_cnt [WIDTH];
    logic [WIDTH-1:0] differ;
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] glitch;

    always_comb begin
        differ = '0;
        accept = '0;
        glitch = '0;
        for (int i = 0; i < WIDTH; i++) begin
            differ[i] = sync_in[i] ^ db_out[i];
            // The current sample is the last one needed to complete the run.
            accept[i] = differ[i] && (run_cnt[i] == C_LAST);
            // A run was in progress and the input fell back to the old level.
            glitch[i] = !differ[i] && (run_cnt[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_out <= '0;
            rise   <= '0;
            fall   <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                run_cnt[i] <= '0;
            end
        end else begin
            rise   <= accept & sync_in;
            fall   <= accept & ~sync_in;
            db_out <= (db_out & ~accept) | (sync_in & accept);
            for (int i = 0; i < WIDTH; i++) begin
                if (accept[i] || !differ[i]) begin
                    run_cnt[i] <= '0;
                end else begin
                    run_cnt[i] <= run_cnt[i] + C_W'(1);
                end
            end
        end
    end

`ifdef GLITCH_CNT_EN
    function automatic logic [POP_W-1:0] pop_count(input logic [WIDTH-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

    // Add with clamp at all-ones; a partial add that would overflow clamps.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [POP_W-1:0] b);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(a) + SUM_W'(b);
        if (sum > SUM_W'({CNT_W{1'b1}})) begin
            return '1;
        end
        return sum[CNT_W-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_cnt <= '0;
        end else if (clr_cnt) begin
            glitch_cnt <= '0;
        end else begin
            glitch_cnt <= sat_add(glitch_cnt, pop_count(glitch));
        end
    end
`else
    assign glitch_cnt = '0;

    // Counter not built: clr_cnt and the glitch flags have no consumer.
    logic unused_glitch_inputs;
    assign unused_glitch_inputs = ^{clr_cnt, glitch};
`endif

endmodule

// File: tb/tb_sync_debounce_edge.sv
module tb_sync_debounce_edge;

    localparam int WIDTH = 4;
    localparam int DB    = 4;
    localparam int CNT_W = 8;
    localparam int GMAX  = 255;
`ifdef GLITCH_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] sync_in = '0;
    logic             clr_cnt = 1'b0;
    logic [WIDTH-1:0] db_out, rise, fall;
    logic [CNT_W-1:0] glitch_cnt;

    sync_debounce_edge #(.WIDTH(WIDTH), .DB_CYCLES(DB), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .sync_in(sync_in), .clr_cnt(clr_cnt),
        .db_out(db_out), .rise(rise), .fall(fall), .glitch_cnt(glitch_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: remembers the most recent samples seen since reset
    // (newest first). A change is accepted when the last DB samples all
    // differ from the debounced level; a glitch is a sample back at the
    // debounced level right after a sample that differed from it.
    bit   hist [WIDTH][DB];
    int   nsamp [WIDTH];
    logic [WIDTH-1:0] m_db, m_rise, m_fall;
    int   m_gc;

    function automatic void model_reset();
        for (int i = 0; i < WIDTH; i++) begin
            nsamp[i] = 0;
            for (int k = 0; k < DB; k++) hist[i][k] = 1'b0;
        end
        m_db = '0; m_rise = '0; m_fall = '0; m_gc = 0;
    endfunction

    function automatic void model_edge(input logic [WIDTH-1:0] s, input logic clr);
        int  n;
        bit  all_diff, prev_diff;
        n = 0;
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int k = DB - 1; k > 0; k--) hist[i][k] = hist[i][k-1];
            hist[i][0] = s[i];
            if (nsamp[i] < DB) nsamp[i]++;
            all_diff = (nsamp[i] == DB);
            for (int k = 0; k < DB; k++) if (hist[i][k] == m_db[i]) all_diff = 1'b0;
            prev_diff = (nsamp[i] >= 2) && (hist[i][1] != m_db[i]);
            if (all_diff) begin
                m_rise[i] = s[i];
                m_fall[i] = ~s[i];
                m_db[i]   = s[i];
            end else if (s[i] == m_db[i] && prev_diff) begin
                n++;
            end
        end
        if (CNT_ON) begin
            if (clr) m_gc = 0;
            else m_gc = (m_gc + n > GMAX) ? GMAX : m_gc + n;
        end
    endfunction

    task automatic step(input logic [WIDTH-1:0] s, input logic c);
        sync_in = s;
        clr_cnt = c;
        @(posedge clk);
        model_edge(s, c);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sync_in = 4'b1011;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (db_out !== 4'b0000) begin bad++; $display("FAIL reset_db got=%b want=0000", db_out); end
        total++; if (rise !== 4'b0000) begin bad++; $display("FAIL reset_rise got=%b want=0000", rise); end
        total++; if (fall !== 4'b0000) begin bad++; $display("FAIL reset_fall got=%b want=0000", fall); end
        total++; if (glitch_cnt !== 8'd0) begin bad++; $display("FAIL reset_gcnt got=%0d want=0", glitch_cnt); end
    endtask

    task automatic test_rise();
        rst_n = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            step(4'b1011, 1'b0);
            if (e < 4) begin
                total++; if (db_out !== 4'b0000 || rise !== 4'b0000) begin bad++; $display("FAIL rise_early edge=%0d db=%b rise=%b want 0000/0000", e, db_out, rise); end
            end
        end
        total++; if (db_out !== 4'b1011) begin bad++; $display("FAIL rise_db got=%b want=1011", db_out); end
        total++; if (rise !== 4'b1011) begin bad++; $display("FAIL rise_pulse got=%b want=1011", rise); end
        total++; if (fall !== 4'b0000) begin bad++; $display("FAIL rise_fall got=%b want=0000", fall); end
        step(4'b1011, 1'b0);
        total++; if (rise !== 4'b0000) begin bad++; $display("FAIL rise_oneshot got=%b want=0000", rise); end
    endtask

    task automatic test_glitch_single();
        step(4'b1111, 1'b0);
        step(4'b1111, 1'b0);
        step(4'b1011, 1'b0);
        total++; if (db_out !== 4'b1011 || rise !== 4'b0000 || fall !== 4'b0000) begin bad++; $display("FAIL glitch1_out db=%b rise=%b fall=%b want 1011/0000/0000", db_out, rise, fall); end
        total++; if (glitch_cnt !== (CNT_ON ? 8'd1 : 8'd0)) begin bad++; $display("FAIL glitch1_cnt got=%0d want=%0d", glitch_cnt, CNT_ON ? 1 : 0); end
    endtask

    task automatic test_glitch_multi();
        repeat (3) step(4'b1000, 1'b0);
        step(4'b1011, 1'b0);
        total++; if (db_out !== 4'b1011) begin bad++; $display("FAIL glitch2_db got=%b want=1011", db_out); end
        total++; if (glitch_cnt !== (CNT_ON ? 8'd3 : 8'd0)) begin bad++; $display("FAIL glitch2_cnt got=%0d want=%0d", glitch_cnt, CNT_ON ? 3 : 0); end
    endtask

    task automatic test_saturate();
        // 3 + 62*4 = 251, then +3 = 254, then +2 clamps to 255.
        for (int r = 0; r < 62; r++) begin
            step(4'b0100, 1'b0);
            step(4'b1011, 1'b0);
        end
        step(4'b1100, 1'b0);
        step(4'b1011, 1'b0);
        total++; if (glitch_cnt !== (CNT_ON ? 8'd254 : 8'd0)) begin bad++; $display("FAIL sat_preload got=%0d want=%0d", glitch_cnt, CNT_ON ? 254 : 0); end
        step(4'b1000, 1'b0);
        step(4'b1011, 1'b0);
        total++; if (glitch_cnt !== (CNT_ON ? 8'd255 : 8'd0)) begin bad++; $display("FAIL sat_clamp got=%0d want=%0d", glitch_cnt, CNT_ON ? 255 : 0); end
        step(4'b0100, 1'b0);
        step(4'b1011, 1'b0);
        total++; if (glitch_cnt !== (CNT_ON ? 8'd255 : 8'd0)) begin bad++; $display("FAIL sat_hold got=%0d want=%0d", glitch_cnt, CNT_ON ? 255 : 0); end
        total++; if (db_out !== m_db) begin bad++; $display("FAIL sat_db got=%b want=%b", db_out, m_db); end
    endtask

    task automatic test_clear();
        step(4'b1010, 1'b0);
        step(4'b1011, 1'b1);
        total++; if (glitch_cnt !== 8'd0) begin bad++; $display("FAIL clear_win got=%0d want=0", glitch_cnt); end
        step(4'b1011, 1'b0);
        total++; if (glitch_cnt !== 8'd0) begin bad++; $display("FAIL clear_stay got=%0d want=0", glitch_cnt); end
    endtask

    task automatic test_reset_midpend();
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
        step(4'b0101, 1'b0);
        step(4'b0101, 1'b0);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        total++; if (db_out !== 4'b0000 || rise !== 4'b0000 || fall !== 4'b0000 || glitch_cnt !== 8'd0) begin bad++; $display("FAIL midpend_async db=%b rise=%b fall=%b gcnt=%0d want all 0", db_out, rise, fall, glitch_cnt); end
        #1;
        rst_n = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            step(4'b0101, 1'b0);
            if (e < 4) begin
                total++; if (rise !== 4'b0000) begin bad++; $display("FAIL midpend_early edge=%0d rise=%b want=0000", e, rise); end
            end
        end
        total++; if (rise !== 4'b0101 || db_out !== 4'b0101) begin bad++; $display("FAIL midpend_rise rise=%b db=%b want 0101/0101", rise, db_out); end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] s;
        logic             c;
        s = db_out;
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < WIDTH; i++) if ($urandom_range(0, 3) == 0) s[i] = ~s[i];
            c = ($urandom_range(0, 40) == 0);
            step(s, c);
            total++;
            if (db_out !== m_db || rise !== m_rise || fall !== m_fall || glitch_cnt !== CNT_W'(m_gc)) begin
                bad++;
                $display("FAIL random n=%0d got db=%b r=%b f=%b g=%0d want db=%b r=%b f=%b g=%0d", n, db_out, rise, fall, glitch_cnt, m_db, m_rise, m_fall, m_gc);
            end
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #2;
                total++; if (db_out !== 4'b0000 || rise !== 4'b0000 || fall !== 4'b0000 || glitch_cnt !== 8'd0) begin bad++; $display("FAIL random_reset db=%b r=%b f=%b g=%0d want all 0", db_out, rise, fall, glitch_cnt); end
                rst_n = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_rise();
        test_glitch_single();
        test_glitch_multi();
        test_saturate();
        test_clear();
        test_reset_midpend();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
